// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma front-end: rotor alphabet size,
// quadrature state encodings and the clockwise successor of each state.
package enigma_pkg;

    localparam int ROTOR_LETTERS = 26;
    localparam int POS_W_DEF     = 5;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_10 = 2'b10,
        QS_11 = 2'b11
    } quad_e;

    localparam quad_e CW_NEXT_11 = QS_10;
    localparam quad_e CW_NEXT_10 = QS_00;
    localparam quad_e CW_NEXT_00 = QS_01;
    localparam quad_e CW_NEXT_01 = QS_11;

    function automatic quad_e cw_next(input quad_e s);
        quad_e n;
        unique case (s)
            QS_11: n = CW_NEXT_11;
            QS_10: n = CW_NEXT_10;
            QS_00: n = CW_NEXT_00;
            QS_01: n = CW_NEXT_01;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; the output
// level only follows the input after DEBOUNCE_CYCLES steady cycles.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Idle-high inputs: everything resets to the released level.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rotary_position_decoder.sv
// Quadrature rotary encoder to wrapped rotor position with button strobe.
// Define ROT_BTN_CLEAR_EN to make a button press reset the position to 0.
module rotary_position_decoder
    import enigma_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 50_000,
    parameter int POS_MAX          = ROTOR_LETTERS - 1,
    parameter int POS_W            = POS_W_DEF,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_sw,
    output logic [POS_W-1:0] position,
    output logic             step_pulse,
    output logic             dir,
    output logic             btn_pulse
);

    localparam int SUB_W = $clog2(STEPS_PER_DETENT) + 2;
    localparam logic signed [SUB_W-1:0] SUB_POS = SUB_W'(STEPS_PER_DETENT);
    localparam logic signed [SUB_W-1:0] SUB_NEG = -SUB_POS;
    localparam logic signed [SUB_W-1:0] SUB_ONE = SUB_W'(1);
    localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_ONE = POS_W'(1);

    logic a_lvl, b_lvl, sw_lvl;
    quad_e cur;

    quad_e                   qs_q, qs_d;
    logic signed [SUB_W-1:0] sub_q, sub_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    btn_q, btn_d;
    logic                    sw_prev_q, sw_prev_d;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .sys_clk(sys_clk), .rst(rst), .raw(enc_a), .level(a_lvl)
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .sys_clk(sys_clk), .rst(rst), .raw(enc_b), .level(b_lvl)
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
        .sys_clk(sys_clk), .rst(rst), .raw(enc_sw), .level(sw_lvl)
    );

    assign cur = quad_e'({a_lvl, b_lvl});

    always_comb begin
        qs_d      = qs_q;
        sub_d     = sub_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        sw_prev_d = sw_lvl;
        btn_d     = sw_prev_q & ~sw_lvl;
        if (cur != qs_q) begin
            qs_d = cur;
            if (cur == cw_next(qs_q)) begin
                sub_d = sub_q + SUB_ONE;
            end else if (qs_q == cw_next(cur)) begin
                sub_d = sub_q - SUB_ONE;
            end else begin
                sub_d = '0;
            end
            // Detent reached: commit only a complete run of transitions.
            if (cur == QS_11) begin
                if (sub_d == SUB_POS) begin
                    pos_d  = (pos_q == P_MAX) ? '0 : pos_q + P_ONE;
                    dir_d  = 1'b1;
                    step_d = 1'b1;
                end else if (sub_d == SUB_NEG) begin
                    pos_d  = (pos_q == '0) ? P_MAX : pos_q - P_ONE;
                    dir_d  = 1'b0;
                    step_d = 1'b1;
                end
                sub_d = '0;
            end
        end
`ifdef ROT_BTN_CLEAR_EN
        if (btn_d) begin
            pos_d  = '0;
            dir_d  = dir_q;
            step_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            qs_q      <= QS_11;
            sub_q     <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            btn_q     <= 1'b0;
            sw_prev_q <= 1'b1;
        end else begin
            qs_q      <= qs_d;
            sub_q     <= sub_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            btn_q     <= btn_d;
            sw_prev_q <= sw_prev_d;
        end
    end

    assign position   = pos_q;
    assign step_pulse = step_q;
    assign dir        = dir_q;
    assign btn_pulse  = btn_q;

endmodule

// File: tb/tb_rotary_position_decoder.sv
// Randomised bench for rotary_position_decoder against a phase-index model.
module tb_rotary_position_decoder;

    localparam int DB   = 8;
    localparam int PMAX = 25;
    localparam int HOLD = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_a = 1'b1;
    logic       enc_b = 1'b1;
    logic       enc_sw = 1'b1;
    logic [4:0] position;
    logic       step_pulse, dir, btn_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;
    int n_btn = 0;

    // reference model state
    int m_pos = 0;
    int m_dir = 0;
    int m_acc = 0;
    int m_ph = 0;
    int m_steps = 0;
    int m_btns = 0;

    rotary_position_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .POS_MAX(PMAX),
        .POS_W(5),
        .STEPS_PER_DETENT(4)
    ) dut (
        .sys_clk(clk),
        .rst(rst),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_sw(enc_sw),
        .position(position),
        .step_pulse(step_pulse),
        .dir(dir),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (step_pulse) n_step++;
            if (btn_pulse) n_btn++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rotation phase: 11=0, 10=1, 00=2, 01=3 going clockwise.
    function automatic int phase_of(input logic [1:0] ab);
        int p;
        case (ab)
            2'b11: p = 0;
            2'b10: p = 1;
            2'b00: p = 2;
            default: p = 3;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        logic [1:0] ab;
        case (p % 4)
            0: ab = 2'b11;
            1: ab = 2'b10;
            2: ab = 2'b00;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

    task automatic model_move(input int np);
        int d;
        d = (np - m_ph + 4) % 4;
        if (d == 1) m_acc++;
        else if (d == 3) m_acc--;
        else if (d == 2) m_acc = 0;
        m_ph = np;
        if (np == 0 && d != 0) begin
            if (m_acc == 4) begin
                m_pos = (m_pos + 1) % (PMAX + 1);
                m_dir = 1;
                m_steps++;
            end else if (m_acc == -4) begin
                m_pos = (m_pos + PMAX) % (PMAX + 1);
                m_dir = 0;
                m_steps++;
            end
            m_acc = 0;
        end
    endtask

    task automatic verify(input string tag);
        chk({tag, ".pos"}, int'(position), m_pos);
        chk({tag, ".dir"}, int'(dir), m_dir);
        chk({tag, ".steps"}, n_step, m_steps);
        chk({tag, ".btns"}, n_btn, m_btns);
    endtask

    task automatic move(input int np, input string tag);
        logic [1:0] ab;
        ab = ab_of(np);
        enc_a = ab[1];
        enc_b = ab[0];
        model_move(np);
        hold(HOLD);
        verify(tag);
    endtask

    task automatic detent(input bit cw, input string tag);
        for (int i = 1; i <= 4; i++) begin
            move(cw ? (m_ph + 1) % 4 : (m_ph + 3) % 4, tag);
        end
    endtask

    task automatic glitch(input bit on_a, input int len);
        if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
        hold(len);
        if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
        hold(HOLD);
        verify("glitch");
    endtask

    task automatic press();
        enc_sw = 1'b0;
        m_btns++;
`ifdef ROT_BTN_CLEAR_EN
        m_pos = 0;
`endif
        hold(30);
        verify("press");
        enc_sw = 1'b1;
        hold(HOLD);
        verify("release");
    endtask

    task automatic do_reset();
        m_pos = 0;
        m_dir = 0;
        m_acc = 0;
        m_ph  = 0;
        rst = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        enc_sw = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(2);
    endtask

    initial begin
        int op;
        int start_steps;
        hold(3);
        chk("rst.pos", int'(position), 0);
        chk("rst.step", int'(step_pulse), 0);
        chk("rst.dir", int'(dir), 0);
        chk("rst.btn", int'(btn_pulse), 0);
        rst = 1'b0;
        hold(2);

        // first detent with exact latency
        move(1, "cw1");
        move(2, "cw1");
        move(3, "cw1");
        enc_a = 1'b1;
        enc_b = 1'b1;
        model_move(0);
        hold(2 + DB);
        chk("lat.before", int'(position), 0);
        hold(1);
        chk("lat.pos", int'(position), 1);
        chk("lat.step", int'(step_pulse), 1);
        chk("lat.dir", int'(dir), 1);
        hold(1);
        chk("lat.step_off", int'(step_pulse), 0);
        hold(HOLD);
        verify("cw1");

        detent(1'b0, "ccw0");
        detent(1'b0, "ccw25");
        chk("wrap.low", int'(position), 25);
        start_steps = n_step;
        for (int i = 0; i < 26; i++) detent(1'b1, "cw26");
        chk("wrap.cnt", n_step - start_steps, 26);
        chk("wrap.pos", int'(position), 25);

        glitch(1'b1, 5);
        move(1, "half");
        move(2, "half");
        move(1, "half");
        move(0, "half");
        detent(1'b1, "after_half");

        move(2, "illegal");
        move(3, "illegal");
        move(0, "illegal");

        // asynchronous reset in the middle of a detent
        move(1, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst.pos", int'(position), 0);
        chk("arst.step", int'(step_pulse), 0);
        chk("arst.dir", int'(dir), 0);
        chk("arst.btn", int'(btn_pulse), 0);
        do_reset();
        detent(1'b1, "post_rst");

        do_reset();
        for (int i = 0; i < 7; i++) detent(1'b1, "to7");
        chk("pos7", int'(position), 7);
        press();

        for (int k = 0; k < 250; k++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0, 1: move((m_ph + 1) % 4, "rnd.cw");
                2, 3: move((m_ph + 3) % 4, "rnd.ccw");
                4: detent(1'b1, "rnd.dcw");
                5: detent(1'b0, "rnd.dccw");
                6: glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, DB - 2)));
                7: move((m_ph + 2) % 4, "rnd.ill");
                default: press();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
